// File: rtl/multicycle_control.sv
// Control FSM sequencing a 64-bit multicycle RISC-V datapath (R-type, addi, ld, sd, beq).
// Latency: outputs decode combinationally from the current state; 3-5 cycles per instruction.
// Backpressure: none; unsupported opcodes park the FSM in HALT until reset.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  output logic       PCWrite,
  output logic [1:0] PCSource,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       LoadAOut,
  output logic       RegWrite,
  output logic       LoadRegA,
  output logic       LoadRegB,
  output logic       MemToReg,
  output logic       DMemRead,
  output logic       DMemWrite,
  output logic       LoadMDR,
  output logic       IMemRead,
  output logic       IRWrite,
  output logic [3:0] state_dbg,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_ALU_WB    = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_PC_INC    = 4'd10,
    S_HALT      = 4'd15
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t state_q, state_d;

  // Next-state selection; opcode is consulted only in DECODE and MEM_ADDR.
  always_comb begin
    state_d = S_HALT;
    case (state_q)
      S_FETCH:     state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_R)                          state_d = S_EXEC_R;
        else if (opcode == OP_ADDI)                  state_d = S_EXEC_I;
        else if (opcode == OP_LD || opcode == OP_SD) state_d = S_MEM_ADDR;
        else if (opcode == OP_BEQ)                   state_d = S_BRANCH;
        else                                         state_d = S_HALT;
      end
      S_EXEC_R:    state_d = S_ALU_WB;
      S_EXEC_I:    state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_MEM_ADDR: begin
        if (opcode == OP_LD)      state_d = S_MEM_READ;
        else if (opcode == OP_SD) state_d = S_MEM_WRITE;
        else                      state_d = S_HALT;
      end
      S_MEM_READ:  state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = S_PC_INC;
      S_BRANCH:    state_d = zero ? S_FETCH : S_PC_INC;
      S_PC_INC:    state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_HALT;
    endcase
  end

  // State register; async reset lands in FETCH at once, aborting any instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Output decode from state (PCWrite in BRANCH follows zero); all forced low while in reset.
  always_comb begin
    PCWrite   = 1'b0;
    PCSource  = 2'd0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'd0;
    ALUOp     = 2'd0;
    LoadAOut  = 1'b0;
    RegWrite  = 1'b0;
    LoadRegA  = 1'b0;
    LoadRegB  = 1'b0;
    MemToReg  = 1'b0;
    DMemRead  = 1'b0;
    DMemWrite = 1'b0;
    LoadMDR   = 1'b0;
    IMemRead  = 1'b0;
    IRWrite   = 1'b0;
    halted    = 1'b0;
    state_dbg = 4'd0;
    if (!reset) begin
      state_dbg = state_q;
      case (state_q)
        S_FETCH: begin
          IMemRead = 1'b1;
          IRWrite  = 1'b1;
        end
        S_DECODE: begin
          // Speculative branch target PC + (imm << 1) into ALUOut.
          LoadRegA = 1'b1;
          LoadRegB = 1'b1;
          ALUSrcB  = 2'd3;
          LoadAOut = 1'b1;
        end
        S_EXEC_R: begin
          ALUSrcA  = 1'b1;
          ALUOp    = 2'b10;
          LoadAOut = 1'b1;
        end
        S_EXEC_I, S_MEM_ADDR: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = 2'd2;
          LoadAOut = 1'b1;
        end
        S_ALU_WB, S_MEM_WB: begin
          // Register writeback and PC + 4 share this cycle.
          RegWrite = 1'b1;
          MemToReg = (state_q == S_MEM_WB);
          ALUSrcB  = 2'd1;
          PCWrite  = 1'b1;
        end
        S_MEM_READ: begin
          // Data memory is addressed by alu_res, so keep the address on the ALU.
          ALUSrcA  = 1'b1;
          ALUSrcB  = 2'd2;
          DMemRead = 1'b1;
          LoadMDR  = 1'b1;
        end
        S_MEM_WRITE: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = 2'd2;
          DMemWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA  = 1'b1;
          ALUOp    = 2'b01;
          PCSource = 2'd1;
          PCWrite  = zero;
        end
        S_PC_INC: begin
          ALUSrcB = 2'd1;
          PCWrite = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
